// File: rtl/jump_redirect_unit_pkg.sv
// Shared definitions for the jump/redirect unit.
//   RESET_PC_DEFAULT : default fetch PC loaded at reset
//   state_e          : redirect FSM states (IDLE / PEND)
//   sel_e            : which request won target selection
package jump_redirect_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_JR  = 2'd1,
        SEL_J   = 2'd2,
        SEL_BR  = 2'd3
    } sel_e;

endpackage

// File: rtl/jump_redirect_unit_target_calc.sv
// target_calc: combinational redirect target selection.
// Priority is JR > J/JAL > branch; with no request the PC advances sequentially.
// Optional feature macro: JR_ALIGN_CHECK_EN (clears JR target bits [1:0]).
// Ports:
//   pc_plus4                          : current PC + 4 (base for J and branch)
//   jump_valid/jump_index             : J/JAL request and raw 26-bit index
//   jr_valid/jr_addr                  : JR request and register target
//   branch_valid/branch_off           : taken branch and raw 16-bit immediate
//   sel                               : winning request
//   target                            : winning target (pc_plus4 when SEL_SEQ)
import jump_redirect_unit_pkg::*;

module target_calc (
    input  logic [31:0] pc_plus4,
    input  logic        jump_valid,
    input  logic [25:0] jump_index,
    input  logic        jr_valid,
    input  logic [31:0] jr_addr,
    input  logic        branch_valid,
    input  logic [15:0] branch_off,
    output sel_e        sel,
    output logic [31:0] target
);

    logic [31:0] jump_tgt;
    logic [31:0] branch_tgt;
    logic [31:0] jr_tgt;

    assign jump_tgt   = {pc_plus4[31:28], jump_index, 2'b00};
    // 32-bit add wraps silently past 2^32
    assign branch_tgt = pc_plus4 + {{14{branch_off[15]}}, branch_off, 2'b00};

`ifdef JR_ALIGN_CHECK_EN
    assign jr_tgt = {jr_addr[31:2], 2'b00};
`else
    assign jr_tgt = jr_addr;
`endif

    always_comb begin
        sel    = SEL_SEQ;
        target = pc_plus4;
        if (jr_valid) begin
            sel    = SEL_JR;
            target = jr_tgt;
        end else if (jump_valid) begin
            sel    = SEL_J;
            target = jump_tgt;
        end else if (branch_valid) begin
            sel    = SEL_BR;
            target = branch_tgt;
        end
    end

endmodule

// File: rtl/jump_redirect_unit.sv
// jump_redirect_unit: fetch PC register with a one-entry redirect buffer that
// holds a redirect arriving while the PC is stalled.
// Optional feature macro: JR_ALIGN_CHECK_EN (misaligned JR -> sticky addr_err_o).
// Ports:
//   clk_i, rst_i    : clock (rising edge), async active-low reset
//   stall_i         : hold the PC
//   jump_valid_i/jump_index_i, jr_valid_i/jr_addr_i,
//   branch_valid_i/branch_off_i : redirect requests
//   pc_o            : current fetch PC
//   pc_plus4_o      : pc_o + 4 (combinational)
//   redirect_o      : one-cycle pulse after each non-sequential PC load
//   pend_o          : a redirect is buffered
//   addr_err_o      : sticky misaligned-JR flag (0 unless feature enabled)
import jump_redirect_unit_pkg::*;

module jump_redirect_unit #(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        jump_valid_i,
    input  logic [25:0] jump_index_i,
    input  logic        jr_valid_i,
    input  logic [31:0] jr_addr_i,
    input  logic        branch_valid_i,
    input  logic [15:0] branch_off_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        redirect_o,
    output logic        pend_o,
    output logic        addr_err_o
);

    state_e      state;
    sel_e        sel;
    logic [31:0] target;
    logic [31:0] buf_pc;

    assign pc_plus4_o = pc_o + 32'd4;
    assign pend_o     = (state == PEND);

    target_calc u_target_calc (
        .pc_plus4     (pc_plus4_o),
        .jump_valid   (jump_valid_i),
        .jump_index   (jump_index_i),
        .jr_valid     (jr_valid_i),
        .jr_addr      (jr_addr_i),
        .branch_valid (branch_valid_i),
        .branch_off   (branch_off_i),
        .sel          (sel),
        .target       (target)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            pc_o       <= RESET_PC;
            buf_pc     <= 32'd0;
            redirect_o <= 1'b0;
        end else begin
            redirect_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (!stall_i) begin
                        pc_o       <= target;
                        // pulse even when a redirect lands on pc+4
                        redirect_o <= (sel != SEL_SEQ);
                    end else if (sel != SEL_SEQ) begin
                        buf_pc <= target;
                        state  <= PEND;
                    end
                end
                PEND: begin
                    // new requests are dropped while a redirect is buffered
                    if (!stall_i) begin
                        pc_o       <= buf_pc;
                        redirect_o <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef JR_ALIGN_CHECK_EN
    // Flag raised when a misaligned JR wins in IDLE, stalled or not
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            addr_err_o <= 1'b0;
        end else if (state == IDLE && sel == SEL_JR && jr_addr_i[1:0] != 2'b00) begin
            addr_err_o <= 1'b1;
        end
    end
`else
    assign addr_err_o = 1'b0;
`endif

endmodule

// File: doc/jump_redirect_unit.md
JUMP_REDIRECT_UNIT -- requirements
Module: jump_redirect_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, which is the PC value loaded at reset.
REQ-002 The block SHALL have port clk_i, input, width 1: the single clock, rising edge.
REQ-003 The block SHALL have port rst_i, input, width 1: reset, asynchronous, active-low.
REQ-004 The block SHALL have port stall_i, input, width 1: PC hold request from the hazard logic.
REQ-005 The block SHALL have port jump_valid_i, input, width 1: J/JAL redirect request.
REQ-006 The block SHALL have port jump_index_i, input, width 26: raw instruction index field.
REQ-007 The block SHALL have port jr_valid_i, input, width 1: JR redirect request.
REQ-008 The block SHALL have port jr_addr_i, input, width 32: register target.
REQ-009 The block SHALL have port branch_valid_i, input, width 1: taken-branch redirect request.
REQ-010 The block SHALL have port branch_off_i, input, width 16: raw branch immediate.
REQ-011 The block SHALL have port pc_o, output, width 32: current fetch PC.
REQ-012 The block SHALL have port pc_plus4_o, output, width 32: pc_o+4, combinational.
REQ-013 The block SHALL have port redirect_o, output, width 1: one-cycle flush pulse.
REQ-014 The block SHALL have port pend_o, output, width 1: a redirect is buffered.
REQ-015 The block SHALL have port addr_err_o, output, width 1: sticky misaligned-JR flag (see REQ-031).

Function
REQ-016 Jump target SHALL be {pc_plus4_o[31:28], jump_index_i, 2'b00}, sampled in the request cycle.
REQ-017 Branch target SHALL be pc_plus4_o + (sign-extended branch_off_i << 2), modulo 2^32, so that wrap-around is silent.
REQ-018 JR target SHALL be jr_addr_i unmodified.
REQ-019 When several request valids are high in the same cycle, priority SHALL be JR > jump > branch; the lower-priority requests are discarded.
REQ-020 The FSM SHALL have two states, IDLE and PEND.
REQ-021 In IDLE with stall_i=0: pc_o SHALL load the winning target, or pc_plus4_o if no request is present.
REQ-022 In IDLE with stall_i=1: pc_o SHALL hold; a winning request SHALL be latched into the pending buffer, and the FSM SHALL go to PEND.
REQ-023 In PEND with stall_i=1: pc_o and the buffer SHALL hold, and any new requests SHALL be ignored.
REQ-024 In PEND with stall_i=0: pc_o SHALL load the buffered target; the FSM SHALL return to IDLE; requests present in that same cycle SHALL be ignored.
REQ-025 pend_o SHALL equal (state==PEND).
REQ-026 redirect_o SHALL be registered and high for exactly one cycle after each pc_o load of a non-sequential target, including a target equal to pc+4.
REQ-027 Latency SHALL be: request to pc_o update is 1 clock when unstalled, and first unstalled edge +1 when stalled.

Reset
REQ-028 On rst_i=0, asynchronously: pc_o SHALL be RESET_PC, state IDLE, buffer cleared, redirect_o=0, pend_o=0, addr_err_o=0.
REQ-029 Reset asserted mid-PEND SHALL discard the buffered redirect with no pulse after release.
REQ-030 The first edge after reset release SHALL behave as IDLE.

Configuration
REQ-031 With macro JR_ALIGN_CHECK_EN defined, a JR winner with jr_addr_i[1:0]!=0 SHALL be taken with bits [1:0] forced to 0, and SHALL set addr_err_o, which holds until reset.
REQ-032 Without JR_ALIGN_CHECK_EN, the JR target SHALL be used verbatim, and addr_err_o SHALL be tied to 0.

Structure
REQ-033 A shared package/include SHALL hold the RESET_PC default, the state encodings IDLE/PEND, and the request-select encoding (SEL_SEQ/SEL_JR/SEL_J/SEL_BR).
REQ-034 Target arithmetic (REQ-016 to REQ-018) SHALL be a combinational sub-module named target_calc; the FSM and registers SHALL stay in the top module.

Verification
REQ-035 Bench SHALL cover: reset release with no requests, 3 edges -> pc_o 0,4,8,12; redirect_o stays 0.
REQ-036 Bench SHALL cover: pc_o=32'h1000_0000, jump_valid_i=1, jump_index_i=26'h0000100 -> next pc_o=32'h1000_0400, with a redirect_o pulse.
REQ-037 Bench SHALL cover: pc_o=32'hFFFF_FFF8, branch_off_i=16'h0001 -> pc_o=32'h0000_0000, which is the wrap case.
REQ-038 Bench SHALL cover: all three valids high, jr_addr_i=32'h0000_2000 -> pc_o=32'h2000.
REQ-039 Bench SHALL cover: branch during a 3-cycle stall, plus a second jump during PEND -> pend_o high for 3 cycles, then pc_o=branch target, and the jump is ignored.
REQ-040 Bench SHALL cover: reset pulse while pend_o=1 -> pc_o=RESET_PC, and no redirect_o after release; with JR_ALIGN_CHECK_EN, jr_addr_i=32'h0000_0102 -> pc_o=32'h100 and addr_err_o=1.
